arduino_cmd_rx: RTL and testbench
=================================

Name: arduino_cmd_rx

Overview:
- UART 8N1 receiver for the Arduino-to-FPGA drive-command link.
- Deserialises command bytes, validates each one against the legal drive-code set, and holds the latest legal code on arduino_command for the manual-mode decoder.
- A link watchdog forces Stop (0x00) if no legal command arrives within a timeout.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- TIMEOUT_CYCLES, 25000000, cycles without a legal command before forcing Stop (0.5 s at 50 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line from Arduino; idles high.
- arduino_command  output  8  latest legal command byte; 0x00 = Stop.
- cmd_valid  output  1  one-cycle pulse when a legal byte is accepted.
- frame_error  output  1  one-cycle pulse on a bad stop bit.
- bad_cmd  output  1  one-cycle pulse when a well-framed byte is not a legal code.
- link_alive  output  1  high while the watchdog has not expired.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset, sampled on the rising edge of clk.
- Reset values:
  - arduino_command=0x00; cmd_valid, frame_error, bad_cmd and link_alive all 0.
  - FSM in IDLE; synchroniser flops = 1; all counters = 0.
  - Reset asserted mid-frame aborts the frame and discards the partial byte.
- Input sync: uart_rx passes through a 2-flop synchroniser; the FSM sees only the synchronised value (rxs).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Let T0 be the cycle rxs=0 is first seen in IDLE.
  - IDLE -> START when rxs=0.
  - START: at T0+CLKS_PER_BIT/2 (integer division), re-sample rxs. If 1, treat as a glitch and return to IDLE with no pulse. If 0, go to DATA.
  - DATA: sample bit i (i=0..7, LSB first) at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT. After bit 7, go to STOP.
  - STOP: sample at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
    - rxs=1: evaluate the byte, go to IDLE.
    - rxs=0: pulse frame_error, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE -> IDLE once rxs=1. No new start is detected until then.
- Legal code set (bit0=w, bit1=a, bit2=s, bit3=d):
  - 0x00 stop, 0x01 fwd, 0x02 left, 0x04 back, 0x08 right.
  - 0x03 fwd-left, 0x09 fwd-right, 0x06 back-left, 0x0C back-right, 0x0A (treated as fwd).
- Accept (legal byte at stop sample):
  - On the following edge, arduino_command <= byte and cmd_valid=1 for exactly one cycle.
  - Watchdog counter clears to 0 and link_alive <= 1.
  - A repeat of the same code still pulses cmd_valid and clears the watchdog.
- Reject (illegal byte): bad_cmd pulses for one cycle; arduino_command, watchdog and link_alive are unchanged.
- Watchdog:
  - Counter width $clog2(TIMEOUT_CYCLES+1). Increments every cycle while link_alive=1.
  - On reaching TIMEOUT_CYCLES: arduino_command <= 0x00, link_alive <= 0, counter holds (saturates). No cmd_valid pulse.
  - While link_alive=0 the counter does not run. After reset, link_alive stays 0 until the first legal byte.
  - If an accept and expiry fall on the same cycle, the accept wins: new code loaded, link_alive=1, counter=0.
- Pulses: cmd_valid, frame_error and bad_cmd are mutually exclusive and never exceed one cycle.
- Back-to-back frames: a start bit immediately after a stop bit is received with no lost byte. The receiver returns to IDLE at mid-stop, so it is ready before the next start edge.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_CYCLES=1000):
- Reset, then send 0x01: cmd_valid pulses once, arduino_command=0x01, link_alive=1. Before that, outputs are 0x00/0/0/0/0.
- Back-to-back 0x03 then 0x0C with no idle gap: two cmd_valid pulses; arduino_command is 0x03, then 0x0C.
- After 0x04, send 0x55: bad_cmd pulses, arduino_command stays 0x04, no cmd_valid, watchdog not cleared.
- Send 0x02 with stop bit held 0 for 3 bit times: frame_error pulses, command unchanged, no start detected until the line returns high. Next 0x08 is accepted.
- Send 0x09, then idle 1000 cycles: arduino_command=0x00 and link_alive=0 exactly 1000 cycles after acceptance. A subsequent 0x01 restores link_alive=1.
- 3-cycle low glitch on an idle line: returns to IDLE, no pulse of any kind. Assert reset mid-DATA, then send 0x06: 0x06 is received cleanly.

Source files
------------

// File: rtl/arduino_cmd_rx.sv
// UART 8N1 receiver for the Arduino drive-command link: validates each byte against
// the legal drive-code set, holds the latest legal code, and falls back to Stop on link loss.
module arduino_cmd_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] arduino_command,
  output logic       cmd_valid,
  output logic       frame_error,
  output logic       bad_cmd,
  output logic       link_alive
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_C   = CW'(CLKS_PER_BIT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state;
  logic            rx_meta, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [WW-1:0]   wd_cnt;
  logic            stop_hit, legal, accept;

  function automatic logic is_legal(input logic [7:0] b);
    case (b)
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
      8'h03, 8'h09, 8'h06, 8'h0C, 8'h0A: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  assign stop_hit = (state == STOP) && (cnt == BIT_C);
  assign legal    = is_legal(shreg);
  assign accept   = stop_hit && rxs && legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // cnt counts cycles since the last sample point (or since T0 in START).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
      bad_cmd     <= 1'b0;
      cmd_valid   <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      bad_cmd     <= 1'b0;
      cmd_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= CW'(1);
          end
        end
        START: begin
          if (cnt == HALF_C) begin
            cnt     <= CW'(1);
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_C) begin
            cnt     <= CW'(1);
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (stop_hit) begin
            cnt <= '0;
            if (rxs) begin
              state     <= IDLE;
              cmd_valid <= legal;
              bad_cmd   <= !legal;
            end else begin
              state       <= WAIT_IDLE;
              frame_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An accept on the expiry cycle takes priority over the forced Stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      arduino_command <= 8'h00;
      link_alive      <= 1'b0;
      wd_cnt          <= '0;
    end else if (accept) begin
      arduino_command <= shreg;
      link_alive      <= 1'b1;
      wd_cnt          <= '0;
    end else if (link_alive) begin
      if (wd_cnt == WD_LAST) begin
        wd_cnt          <= WD_MAX;
        link_alive      <= 1'b0;
        arduino_command <= 8'h00;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Directed bench for arduino_cmd_rx: a scoreboard queue of expected pulses is filled
// as frames are sent and drained by a negedge monitor; inline checks cover state.
module tb_arduino_cmd_rx;
  localparam int CPB = 8;
  localparam int TO  = 1000;
  localparam logic [1:0] K_VALID = 2'd0, K_BAD = 2'd1, K_FRAME = 2'd2;

  typedef struct { logic [1:0] kind; logic [7:0] code; } exp_t;

  logic       gclk = 1'b0;
  logic       reset, uart_rx;
  logic [7:0] arduino_command;
  logic       cmd_valid, frame_error, bad_cmd, link_alive;

  exp_t       sb[$];
  int         n_cmp = 0, n_err = 0;
  int         cyc = 0, last_valid_cyc = 0;

  arduino_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(gclk), .reset(reset), .uart_rx(uart_rx),
    .arduino_command(arduino_command), .cmd_valid(cmd_valid),
    .frame_error(frame_error), .bad_cmd(bad_cmd), .link_alive(link_alive)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pulse_kind();
    if (cmd_valid)    return K_VALID;
    if (bad_cmd)      return K_BAD;
    return K_FRAME;
  endfunction

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge gclk) begin
    if (!reset && (cmd_valid || bad_cmd || frame_error)) begin
      check("pulse_onehot", 32'(cmd_valid) + 32'(bad_cmd) + 32'(frame_error), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, cmd_valid, bad_cmd, frame_error}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'(pulse_kind()), 32'(e.kind));
        if (cmd_valid) begin
          check("pulse_code", 32'(arduino_command), 32'(e.code));
          last_valid_cyc = cyc;
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) begin @(posedge gclk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low_bits);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (stop_low_bits > 0) drive(1'b0, stop_low_bits * CPB);
    else drive(1'b1, CPB);
  endtask

  task automatic expect_pulse(input logic [1:0] k, input logic [7:0] c);
    exp_t e;
    e.kind = k; e.code = c;
    sb.push_back(e);
  endtask

  task automatic wait_link_drop(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge gclk); #1;
      if (!link_alive) seen = 1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - last_valid_cyc), 32'(TO));
      check({tag, "_cmd"}, 32'(arduino_command), 32'h00);
    end
  endtask

  initial begin
    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (4) @(posedge gclk);
    #1;
    check("rst_cmd", 32'(arduino_command), 32'h00);
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_bad", 32'(bad_cmd), 32'd0);
    check("rst_alive", 32'(link_alive), 32'd0);
    reset = 1'b0;
    drive(1'b1, 10);
    check("idle_alive", 32'(link_alive), 32'd0);

    expect_pulse(K_VALID, 8'h01);
    send_byte(8'h01, 0);
    check("fwd_cmd", 32'(arduino_command), 32'h01);
    check("fwd_alive", 32'(link_alive), 32'd1);

    expect_pulse(K_VALID, 8'h03);
    expect_pulse(K_VALID, 8'h0C);
    send_byte(8'h03, 0);
    send_byte(8'h0C, 0);
    check("b2b_cmd", 32'(arduino_command), 32'h0C);
    drive(1'b1, 4);

    expect_pulse(K_VALID, 8'h04);
    send_byte(8'h04, 0);
    expect_pulse(K_BAD, 8'h00);
    send_byte(8'h55, 0);
    check("bad_cmd_hold", 32'(arduino_command), 32'h04);
    check("bad_alive", 32'(link_alive), 32'd1);
    wait_link_drop("bad_wd", 1200);

    expect_pulse(K_FRAME, 8'h00);
    send_byte(8'h02, 3);
    check("ferr_cmd", 32'(arduino_command), 32'h00);
    drive(1'b1, 2 * CPB);
    expect_pulse(K_VALID, 8'h08);
    send_byte(8'h08, 0);
    check("after_ferr_cmd", 32'(arduino_command), 32'h08);
    drive(1'b1, 4);

    expect_pulse(K_VALID, 8'h09);
    send_byte(8'h09, 0);
    check("pre_to_cmd", 32'(arduino_command), 32'h09);
    wait_link_drop("timeout", 1200);
    expect_pulse(K_VALID, 8'h01);
    send_byte(8'h01, 0);
    check("restore_alive", 32'(link_alive), 32'd1);
    check("restore_cmd", 32'(arduino_command), 32'h01);

    drive(1'b0, 3);
    drive(1'b1, 3 * CPB);
    check("glitch_cmd", 32'(arduino_command), 32'h01);

    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b1, 3);
    reset = 1'b1;
    drive(1'b1, 2);
    reset = 1'b0;
    check("midrst_cmd", 32'(arduino_command), 32'h00);
    check("midrst_alive", 32'(link_alive), 32'd0);
    drive(1'b1, 4);
    expect_pulse(K_VALID, 8'h06);
    send_byte(8'h06, 0);
    check("post_rst_cmd", 32'(arduino_command), 32'h06);
    drive(1'b1, 2 * CPB);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
